// File: rtl/rv32m_muldiv.sv
// RV32M multiply/divide unit: two-cycle multiplier plus a 32-step radix-2 restoring divider.
// Optional macro MULDIV_EARLY_OUT_EN lets divide-by-zero and signed-overflow divides skip iterating.
module rv32m_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH-1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r, fsm_next_s, state_next_s;
    logic             ready_r, valid_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, q_r, rem_r, res_r, held_r;
    logic [CW-1:0]    count_r;
    logic             accept_s, early_s;
    logic [WIDTH-1:0] dmag_s, q_next_s, rem_next_s;
    logic [WIDTH:0]   rem_shift_s, diff_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    // Sign fix-up of the unsigned quotient/remainder; divide-by-zero results are architectural constants.
    function automatic logic [WIDTH-1:0] div_result(input logic is_signed, input logic want_rem,
                                                    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                    input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r);
        logic             a_neg, b_neg, dz;
        logic [WIDTH-1:0] quot, rmd;
        a_neg = is_signed & a[WIDTH-1];
        b_neg = is_signed & b[WIDTH-1];
        dz    = (b == ZERO);
        quot  = dz ? ALL_ONES : ((a_neg ^ b_neg) ? -q : q);
        rmd   = dz ? a : (a_neg ? -r : r);
        return want_rem ? rmd : quot;
    endfunction

    function automatic logic [WIDTH-1:0] mul_result(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic               a_sx, b_sx;
        logic [2*WIDTH-1:0] a_w, b_w, p;
        a_sx = ((op == 3'b001) || (op == 3'b010)) & a[WIDTH-1];
        b_sx = (op == 3'b001) & b[WIDTH-1];
        a_w  = {{WIDTH{a_sx}}, a};
        b_w  = {{WIDTH{b_sx}}, b};
        p    = a_w * b_w;
        if (op[1:0] == 2'b00) begin
            return p[WIDTH-1:0];
        end else begin
            return p[2*WIDTH-1:WIDTH];
        end
    endfunction

    assign accept_s = i_valid & ready_r & ~i_flush;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_s = (i_rs2 == ZERO) | (~i_op[0] & (i_rs1 == MIN_NEG) & (i_rs2 == ALL_ONES));
`else
    assign early_s = 1'b0;
`endif

    // Next-state decode; flush overrides everything, including a same-cycle accept.
    always_comb begin
        fsm_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !i_op[2]) begin
                    fsm_next_s = ST_MUL;
                end else if (accept_s && early_s) begin
                    fsm_next_s = ST_DONE;
                end else if (accept_s) begin
                    fsm_next_s = ST_DIV;
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_MUL:  fsm_next_s = ST_DONE;
            ST_DIV: begin
                if (count_r == LAST_STEP) begin
                    fsm_next_s = ST_DONE;
                end else begin
                    fsm_next_s = ST_DIV;
                end
            end
            ST_DONE: fsm_next_s = ST_IDLE;
            default: fsm_next_s = ST_IDLE;
        endcase
        state_next_s = i_flush ? ST_IDLE : fsm_next_s;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        dmag_s      = magnitude(b_r, ~op_r[0]);
        rem_shift_s = {rem_r, q_r[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, dmag_s};
        if (!diff_s[WIDTH]) begin
            rem_next_s = diff_s[WIDTH-1:0];
            q_next_s   = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
            q_next_s   = {q_r[WIDTH-2:0], 1'b0};
        end
    end

    // State register with registered ready/valid decoded from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_IDLE);
            valid_r <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, divider iteration and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_r    <= 3'd0;
            a_r     <= ZERO;
            b_r     <= ZERO;
            q_r     <= ZERO;
            rem_r   <= ZERO;
            count_r <= {CW{1'b0}};
            res_r   <= ZERO;
            held_r  <= ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r    <= i_op;
                        a_r     <= i_rs1;
                        b_r     <= i_rs2;
                        q_r     <= magnitude(i_rs1, ~i_op[0]);
                        rem_r   <= ZERO;
                        count_r <= {CW{1'b0}};
                        if (i_op[2] && early_s) begin
                            res_r <= div_result(~i_op[0], i_op[1], i_rs1, i_rs2, MIN_NEG, ZERO);
                        end
                    end
                end
                ST_MUL: res_r <= mul_result(op_r, a_r, b_r);
                ST_DIV: begin
                    q_r     <= q_next_s;
                    rem_r   <= rem_next_s;
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (count_r == LAST_STEP) begin
                        res_r <= div_result(~op_r[0], op_r[1], a_r, b_r, q_next_s, rem_next_s);
                    end
                end
                ST_DONE: begin
                    if (!i_flush) begin
                        held_r <= res_r;
                    end
                end
                default: held_r <= held_r;
            endcase
        end
    end

    // A flush in DONE hides the new result and keeps the previously delivered one visible.
    assign o_ready  = ready_r;
    assign o_valid  = valid_r & ~i_flush;
    assign o_result = o_valid ? res_r : held_r;

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Self-checking bench for rv32m_muldiv: arithmetic reference model with per-cycle compare,
// plus directed vectors whose results and latencies are written out by hand.
module tb_rv32m_muldiv;
    logic        i_clk = 1'b0;
    logic        i_rst_n, i_valid, i_flush, o_ready, o_valid;
    logic [2:0]  i_op;
    logic [31:0] i_rs1, i_rs2, o_result;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    logic busy = 1'b0;
    logic chk_en = 1'b0;
    logic [31:0] m_exp = 32'd0;
    logic [31:0] m_held = 32'd0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    rv32m_muldiv #(.WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush),
        .o_valid(o_valid), .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_res_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int exp_lat_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return 33;
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference model: busy from the accept edge through the result cycle, result due at done_cyc.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy   <= 1'b0;
            m_held <= 32'd0;
        end else if (busy) begin
            if (i_flush) begin
                busy <= 1'b0;
            end else if (cyc == done_cyc) begin
                busy   <= 1'b0;
                m_held <= m_exp;
            end
        end else if (i_valid && !i_flush) begin
            busy     <= 1'b1;
            m_exp    <= exp_res_f(i_op, i_rs1, i_rs2);
            done_cyc <= cyc + exp_lat_f(i_op, i_rs1, i_rs2);
        end
    end

    always @(negedge i_clk) begin
        if (chk_en && i_rst_n) begin
            check("cyc_valid", {31'd0, o_valid}, {31'd0, busy && (cyc == done_cyc) && !i_flush});
            check("cyc_ready", {31'd0, o_ready}, {31'd0, !busy});
            check("cyc_result", o_result, (busy && (cyc == done_cyc) && !i_flush) ? m_exp : m_held);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name, input bit pin);
        int k;
        k = 0;
        while (!o_ready && k < 50) begin tick(); k++; end
        check({name, "_rdy_wait"}, {31'd0, o_ready}, 32'd1);
        if (pin) begin
            check({name, "_model"}, exp_res_f(op, a, b), exp);
            check({name, "_model_lat"}, 32'(exp_lat_f(op, a, b)), 32'(lat));
        end
        i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b;
        tick();
        i_valid = 1'b0;
        check({name, "_busy"}, {31'd0, o_ready}, 32'd0);
        k = 1;
        while (!o_valid && k < 40) begin tick(); k++; end
        check({name, "_lat"}, 32'(k), 32'(lat));
        check({name, "_res"}, o_result, exp);
        tick();
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_op = 3'd0; i_rs1 = 32'd0; i_rs2 = 32'd0;
        repeat (3) tick();
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_result", o_result, 32'd0);
        i_rst_n = 1'b1;
        chk_en  = 1'b1;
        tick();

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2,  "mul", 1'b1);
        run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 2,  "mulh", 1'b1);
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2,  "mulhu", 1'b1);
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  "mulhsu", 1'b1);
        run_op(3'd3, 32'h8000_0000,  32'd2,         32'h0000_0001, 2,  "mulhu_carry", 1'b1);
        run_op(3'd5, 32'd100,        32'd7,         32'd14,        33, "divu", 1'b1);
        run_op(3'd7, 32'd100,        32'd7,         32'd2,         33, "remu", 1'b1);
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div_neg", 1'b1);
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem_neg", 1'b1);
        run_op(3'd4, 32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, 33, "div_negb", 1'b1);
        run_op(3'd6, 32'd20,         32'hFFFF_FFFA, 32'd2,         33, "rem_negb", 1'b1);
        run_op(3'd4, 32'hFFFF_FFEC,  32'hFFFF_FFFA, 32'd3,         33, "div_both", 1'b1);
        run_op(3'd6, 32'hFFFF_FFEC,  32'hFFFF_FFFA, 32'hFFFF_FFFE, 33, "rem_both", 1'b1);
        run_op(3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33, "divu_max", 1'b1);
        run_op(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, EO_LAT, "div_by0", 1'b1);
        run_op(3'd6, 32'd5,          32'd0,         32'd5,         EO_LAT, "rem_by0", 1'b1);
        run_op(3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, EO_LAT, "divu_by0", 1'b1);
        run_op(3'd7, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, EO_LAT, "remu_by0", 1'b1);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, EO_LAT, "div_ovf", 1'b1);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         EO_LAT, "rem_ovf", 1'b1);
        run_op(3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33, "divu_noovf", 1'b1);

        // Flush in the same cycle as a request: nothing is accepted.
        i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd0; i_rs1 = 32'd9; i_rs2 = 32'd9;
        tick();
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush_acc_ready", {31'd0, o_ready}, 32'd1);
        tick();
        check("flush_acc_valid", {31'd0, o_valid}, 32'd0);

        // Flush at iteration 10 of a divide.
        i_valid = 1'b1; i_op = 3'd4; i_rs1 = 32'd100; i_rs2 = 32'd7;
        tick();
        i_valid = 1'b0;
        repeat (10) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush_div_ready", {31'd0, o_ready}, 32'd1);
        check("flush_div_valid", {31'd0, o_valid}, 32'd0);
        check("flush_div_hold", o_result, 32'd0);
        repeat (40) tick();
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 2, "mul_after_flush", 1'b1);

        // Flush while the result is being presented.
        i_valid = 1'b1; i_op = 3'd0; i_rs1 = 32'd5; i_rs2 = 32'd5;
        tick();
        i_valid = 1'b0;
        tick();
        i_flush = 1'b1;
        #1;
        check("flush_done_valid", {31'd0, o_valid}, 32'd0);
        check("flush_done_hold", o_result, 32'd12);
        tick();
        i_flush = 1'b0;
        check("flush_done_ready", {31'd0, o_ready}, 32'd1);
        check("flush_done_keep", o_result, 32'd12);

        // Back-to-back: second request held high is taken only the cycle after DONE.
        i_valid = 1'b1; i_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd4;
        tick();
        i_op = 3'd3; i_rs1 = 32'h8000_0000; i_rs2 = 32'd2;
        check("b2b_busy", {31'd0, o_ready}, 32'd0);
        tick();
        check("b2b_first_valid", {31'd0, o_valid}, 32'd1);
        check("b2b_first_res", o_result, 32'd12);
        check("b2b_done_ready", {31'd0, o_ready}, 32'd0);
        tick();
        check("b2b_idle_ready", {31'd0, o_ready}, 32'd1);
        check("b2b_idle_valid", {31'd0, o_valid}, 32'd0);
        tick();
        i_valid = 1'b0;
        check("b2b_accepted", {31'd0, o_ready}, 32'd0);
        tick();
        check("b2b_second_valid", {31'd0, o_valid}, 32'd1);
        check("b2b_second_res", o_result, 32'd1);
        tick();

        // Asynchronous reset in the middle of a divide.
        i_valid = 1'b1; i_op = 3'd5; i_rs1 = 32'd1000; i_rs2 = 32'd3;
        tick();
        i_valid = 1'b0;
        repeat (5) tick();
        i_rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, o_valid}, 32'd0);
        check("arst_ready", {31'd0, o_ready}, 32'd1);
        check("arst_result", o_result, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        run_op(3'd7, 32'd1000, 32'd3, 32'd1, 33, "remu_after_rst", 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = i[0] ? $urandom : $urandom_range(0, 9);
            run_op(rop, ra, rb, exp_res_f(rop, ra, rb), exp_lat_f(rop, ra, rb), "rnd", 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
